// File: rtl/multicycle_datapath.sv
// Multi-cycle RV-style integer datapath.
// A Moore FSM steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB.
// Instruction and data memories sit outside the block behind req/ready
// handshakes, so wait-stated memories are supported.
// Ports:
//   clk, reset        : single clock; synchronous active-low reset
//   imem_*            : fetch request/address, ready/instruction word
//   dmem_*            : data request, store enable, address, store data, ready, load data
//   dbg_raddr/rdata   : combinational register read for debug
//   pc, instr         : current PC and instruction register
//   retired           : high during the final cycle of each completed instruction
//   halt, error       : sticky stop flags; error marks an illegal instruction or misaligned PC
module multicycle_datapath #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic            retired,
  output logic            halt,
  output logic            error
);

  localparam int unsigned RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ILL, C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_ECALL
  } iclass_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] mdr_q, mdr_d;
  logic            halt_q, halt_d;
  logic            error_q, error_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [6:0]      f7;
  iclass_t         cls;
  logic [XLEN-1:0] imm_gen;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] alu_res;
  logic            br_taken;
  logic            retire;
  logic            err_set;
  logic            wr_en;
  logic [XLEN-1:0] wr_data;

  // Register index fits the implemented file.
  function automatic logic idx_ok(input logic [4:0] idx);
    return 32'(idx) < NREGS;
  endfunction

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  // Operand reads; x0 and out-of-range indices read as zero.
  assign rs1_val   = (rs1 == 5'd0 || !idx_ok(rs1)) ? '0 : regs_q[rs1[RIDX_W-1:0]];
  assign rs2_val   = (rs2 == 5'd0 || !idx_ok(rs2)) ? '0 : regs_q[rs2[RIDX_W-1:0]];
  assign dbg_rdata = (dbg_raddr == 5'd0 || !idx_ok(dbg_raddr)) ? '0
                                                               : regs_q[dbg_raddr[RIDX_W-1:0]];

  // Instruction classification; anything not matched stays illegal.
  always_comb begin
    cls = C_ILL;
    case (opcode)
      OP_R: begin
        if (idx_ok(rs1) && idx_ok(rs2) && idx_ok(rd) &&
            ((f7 == 7'h00 && f3 != 3'b001 && f3 != 3'b101) ||
             (f7 == 7'h20 && f3 == 3'b000)))
          cls = C_ALU;
      end
      OP_I: begin
        if (idx_ok(rs1) && idx_ok(rd) && f3 != 3'b001 && f3 != 3'b101)
          cls = C_ALU;
      end
      OP_LOAD: begin
        if (idx_ok(rs1) && idx_ok(rd)) cls = C_LOAD;
      end
      OP_STORE: begin
        if (idx_ok(rs1) && idx_ok(rs2)) cls = C_STORE;
      end
      OP_BRANCH: begin
        if (idx_ok(rs1) && idx_ok(rs2) && f3 != 3'b010 && f3 != 3'b011)
          cls = C_BRANCH;
      end
      OP_JAL: begin
        if (idx_ok(rd)) cls = C_JAL;
      end
      OP_SYSTEM: begin
        // Only the exact ecall encoding is accepted.
        if (ir_q == 32'h0000_0073) cls = C_ECALL;
      end
      default: cls = C_ILL;
    endcase
  end

  // Sign-extended immediate by format.
  always_comb begin
    imm_gen = '0;
    case (opcode)
      OP_I, OP_LOAD: imm_gen = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
      OP_STORE:      imm_gen = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OP_BRANCH:     imm_gen = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7],
                                ir_q[30:25], ir_q[11:8], 1'b0};
      OP_JAL:        imm_gen = {{(XLEN-21){ir_q[31]}}, ir_q[31], ir_q[19:12],
                                ir_q[20], ir_q[30:21], 1'b0};
      default:       imm_gen = '0;
    endcase
  end

  // ALU; defaults to rs1 + imm, which is also the load/store address.
  assign op2 = (opcode == OP_R) ? b_q : imm_q;

  always_comb begin
    alu_res = a_q + imm_q;
    if (cls == C_ALU) begin
      case (f3)
        3'b000:  alu_res = (opcode == OP_R && f7[5]) ? a_q - op2 : a_q + op2;
        3'b010:  alu_res = XLEN'($signed(a_q) < $signed(op2));
        3'b011:  alu_res = XLEN'(a_q < op2);
        3'b100:  alu_res = a_q ^ op2;
        3'b110:  alu_res = a_q | op2;
        3'b111:  alu_res = a_q & op2;
        default: alu_res = a_q + op2;
      endcase
    end
  end

  // Branch condition.
  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'b000:  br_taken = (a_q == b_q);
      3'b001:  br_taken = (a_q != b_q);
      3'b100:  br_taken = ($signed(a_q) <  $signed(b_q));
      3'b101:  br_taken = ($signed(a_q) >= $signed(b_q));
      3'b110:  br_taken = (a_q <  b_q);
      3'b111:  br_taken = (a_q >= b_q);
      default: br_taken = 1'b0;
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    retire  = 1'b0;
    err_set = 1'b0;
    wr_en   = 1'b0;
    wr_data = alu_q;

    case (state_q)
      S_FETCH: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d = S_HALT;
          err_set = 1'b1;
        end else if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rs1_val;
        b_d     = rs2_val;
        imm_d   = imm_gen;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_d = alu_res;
        case (cls)
          C_BRANCH: begin
            pc_d    = br_taken ? pc_q + imm_q : pc_q + PC_STEP;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          C_ALU, C_JAL:    state_d = S_WB;
          C_ECALL:         state_d = S_HALT;
          default: begin
            state_d = S_HALT;
            err_set = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (cls == C_STORE) begin
            pc_d    = pc_q + PC_STEP;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_d   = dmem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        wr_en = 1'b1;
        if (cls == C_LOAD)     wr_data = mdr_q;
        else if (cls == C_JAL) wr_data = pc_q + PC_STEP;
        else                   wr_data = alu_q;
        pc_d    = (cls == C_JAL) ? pc_q + imm_q : pc_q + PC_STEP;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        err_set = 1'b1;
      end
    endcase

    halt_d  = halt_q | (state_d == S_HALT);
    error_d = error_q | err_set;
  end

  // Register file update; x0 writes are dropped.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && rd != 5'd0 && idx_ok(rd)) regs_d[rd[RIDX_W-1:0]] = wr_data;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      halt_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      halt_q  <= halt_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Moore requests, forced low while reset is held.
  assign imem_req   = reset && (state_q == S_FETCH) && (pc_q[1:0] == 2'b00);
  assign imem_addr  = pc_q;
  assign dmem_req   = reset && (state_q == S_MEM);
  assign dmem_we    = (state_q == S_MEM) && (cls == C_STORE);
  assign dmem_addr  = alu_q;
  assign dmem_wdata = b_q;
  assign retired    = reset && retire;
  assign pc         = pc_q;
  assign instr      = ir_q;
  assign halt       = halt_q;
  assign error      = error_q;

endmodule
